// File: rtl/rr_select_arbiter.sv
// rr_select_arbiter: round-robin arbiter for four requesters. It produces
// the registered 2-bit select (oS1, oS0) for a downstream 4-to-1 mux.
// Each winner keeps the grant for up to HOLD_CYCLES cycles, or for less
// time if it drops its request. Priority then rotates past the winner.
module rr_select_arbiter #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iEn,
    input  logic [3:0] iReq,
    output logic       oS1,
    output logic       oS0,
    output logic [3:0] oGrant,
    output logic       oValid,
    output logic       oSwitch
);

    localparam logic       ST_IDLE  = 1'b0;
    localparam logic       ST_GRANT = 1'b1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLD_CYCLES - 1);

    logic             r_state;
    logic [1:0]       r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_sel;
    logic [3:0]       r_grant;
    logic             r_valid;
    logic             r_switch;

    logic             w_found;
    logic [1:0]       w_win;
    logic [1:0]       w_idx;
    logic             w_arbEvent;
    logic             w_release;

    // Rotated priority search. Offsets are scanned from the highest down
    // to the lowest, so the channel nearest the pointer is assigned last
    // and therefore wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_idx   = r_ptr;
        for (int i = 3; i >= 0; i--) begin
            w_idx = r_ptr + 2'(i);
            if (iReq[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // An arbitration needs the enable and at least one request. The current
    // grant ends early when its own request drops or when its dwell runs out.
    always_comb begin
        w_arbEvent = iEn && w_found;
        w_release  = !iReq[r_sel] || (r_cnt == '0);
    end

    // Main state, pointer, counter and registered-output update. The select
    // lines keep their last value while idle, so the mux does not toggle.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state  <= ST_IDLE;
            r_ptr    <= 2'd0;
            r_cnt    <= '0;
            r_sel    <= 2'd0;
            r_grant  <= 4'b0000;
            r_valid  <= 1'b0;
            r_switch <= 1'b0;
        end else begin
            r_switch <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_arbEvent) begin
                        r_state  <= ST_GRANT;
                        r_sel    <= w_win;
                        r_grant  <= 4'b0001 << w_win;
                        r_valid  <= 1'b1;
                        r_switch <= 1'b1;
                        r_cnt    <= CNT_RELOAD;
                        r_ptr    <= w_win + 2'd1;
                    end
                end
                ST_GRANT: begin
                    if (!iEn) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_grant <= 4'b0000;
                    end else if (w_release) begin
                        if (w_found) begin
                            r_sel    <= w_win;
                            r_grant  <= 4'b0001 << w_win;
                            r_valid  <= 1'b1;
                            r_switch <= 1'b1;
                            r_cnt    <= CNT_RELOAD;
                            r_ptr    <= w_win + 2'd1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_valid <= 1'b0;
                            r_grant <= 4'b0000;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_grant <= 4'b0000;
                end
            endcase
        end
    end

    assign oS1     = r_sel[1];
    assign oS0     = r_sel[0];
    assign oGrant  = r_grant;
    assign oValid  = r_valid;
    assign oSwitch = r_switch;

endmodule

// File: tb/tb_rr_select_arbiter.sv
// Testbench for rr_select_arbiter with HOLD_CYCLES=4. Directed vectors are
// applied on the falling edge, and each one queues the hand-derived outputs
// expected after the next rising edge. A separate monitor pops the queue
// and compares the outputs. It also checks that a selector41 fed with
// iCn = 1<<n would produce the same pattern as oGrant.
module tb_rr_select_arbiter;

    logic       iClk;
    logic       iRst;
    logic       iEn;
    logic [3:0] iReq;
    logic       oS1;
    logic       oS0;
    logic [3:0] oGrant;
    logic       oValid;
    logic       oSwitch;

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] grant;
        logic       valid;
        logic       sw;
    } exp_t;

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;
    int   stepNum  = 0;

    rr_select_arbiter #(.HOLD_CYCLES(4), .CNT_W(8)) dut (
        .iClk    (iClk),
        .iRst    (iRst),
        .iEn     (iEn),
        .iReq    (iReq),
        .oS1     (oS1),
        .oS0     (oS0),
        .oGrant  (oGrant),
        .oValid  (oValid),
        .oSwitch (oSwitch)
    );

    // Free-running clock, 10 time units per period
    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    // Drive one cycle of inputs and queue the outputs expected after the edge
    task automatic applyStimulus(input logic rst, input logic en, input logic [3:0] req,
                                 input logic [1:0] sel, input logic [3:0] grant,
                                 input logic valid, input logic sw);
        exp_t e;
        @(negedge iClk);
        iRst = rst;
        iEn  = en;
        iReq = req;
        e.sel   = sel;
        e.grant = grant;
        e.valid = valid;
        e.sw    = sw;
        expQ.push_back(e);
    endtask

    // Compare the DUT outputs with one queued expectation, plus the mux consistency check
    task automatic checkOutput(input exp_t e);
        exp_t got;
        logic [3:0] muxZ;
        got.sel   = {oS1, oS0};
        got.grant = oGrant;
        got.valid = oValid;
        got.sw    = oSwitch;
        stepNum++;
        checks++;
        if (got !== e) begin
            failures++;
            $display("[TB] FAIL step%0d outputs: got sel=%b grant=%b valid=%b switch=%b, required sel=%b grant=%b valid=%b switch=%b",
                     stepNum, got.sel, got.grant, got.valid, got.sw, e.sel, e.grant, e.valid, e.sw);
        end
        if (oValid === 1'b1) begin
            muxZ = 4'b0001 << {oS1, oS0};
            checks++;
            if (muxZ !== oGrant) begin
                failures++;
                $display("[TB] FAIL step%0d mux_onehot: oZ=%b, required oGrant=%b", stepNum, muxZ, oGrant);
            end
        end
    endtask

    // Monitor: samples 1 unit after every rising edge and compares against the queue
    always @(posedge iClk) begin
        #1;
        if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end

    initial begin
        iRst = 1'b1;
        iEn  = 1'b1;
        iReq = 4'b1111;

        // Reset held for two edges with everything requesting
        applyStimulus(1, 1, 4'b1111, 2'b00, 4'b0000, 0, 0);
        applyStimulus(1, 1, 4'b1111, 2'b00, 4'b0000, 0, 0);

        // Full rotation: 0,1,2,3,0, each held for four cycles with a switch pulse first
        for (int ch = 0; ch < 5; ch++) begin
            applyStimulus(0, 1, 4'b1111, 2'(ch), 4'b0001 << 2'(ch), 1, 1);
            for (int k = 0; k < 3; k++)
                applyStimulus(0, 1, 4'b1111, 2'(ch), 4'b0001 << 2'(ch), 1, 0);
        end

        // Early release: ch2 alone wins at ch0 expiry (ptr=1), then drops for 1001
        applyStimulus(0, 1, 4'b0100, 2'b10, 4'b0100, 1, 1);
        applyStimulus(0, 1, 4'b0100, 2'b10, 4'b0100, 1, 0);
        applyStimulus(0, 1, 4'b1001, 2'b11, 4'b1000, 1, 1);
        applyStimulus(0, 1, 4'b1001, 2'b11, 4'b1000, 1, 0);
        applyStimulus(0, 1, 4'b1001, 2'b11, 4'b1000, 1, 0);
        applyStimulus(0, 1, 4'b1001, 2'b11, 4'b1000, 1, 0);
        applyStimulus(0, 1, 4'b1001, 2'b00, 4'b0001, 1, 1);

        // Sole requester ch1: re-granted on expiry with a fresh switch pulse
        applyStimulus(0, 1, 4'b0010, 2'b01, 4'b0010, 1, 1);
        for (int k = 0; k < 3; k++)
            applyStimulus(0, 1, 4'b0010, 2'b01, 4'b0010, 1, 0);
        applyStimulus(0, 1, 4'b0010, 2'b01, 4'b0010, 1, 1);
        applyStimulus(0, 1, 4'b0010, 2'b01, 4'b0010, 1, 0);

        // Disable mid-grant: idle with the select held, then re-enable and win ch2
        applyStimulus(0, 0, 4'b0010, 2'b01, 4'b0000, 0, 0);
        applyStimulus(0, 0, 4'b1111, 2'b01, 4'b0000, 0, 0);
        applyStimulus(0, 1, 4'b1111, 2'b10, 4'b0100, 1, 1);

        // ch2 runs out its dwell, then all requests vanish
        for (int k = 0; k < 3; k++)
            applyStimulus(0, 1, 4'b0100, 2'b10, 4'b0100, 1, 0);
        applyStimulus(0, 1, 4'b0000, 2'b10, 4'b0000, 0, 0);
        applyStimulus(0, 1, 4'b0000, 2'b10, 4'b0000, 0, 0);

        // Reset in the middle of a ch3 grant
        applyStimulus(0, 1, 4'b1000, 2'b11, 4'b1000, 1, 1);
        applyStimulus(0, 1, 4'b1000, 2'b11, 4'b1000, 1, 0);
        applyStimulus(1, 1, 4'b1000, 2'b00, 4'b0000, 0, 0);

        // Reset mid-grant while ptr=2 must still restart priority at ch0
        applyStimulus(0, 1, 4'b0010, 2'b01, 4'b0010, 1, 1);
        applyStimulus(1, 1, 4'b1111, 2'b00, 4'b0000, 0, 0);
        applyStimulus(0, 1, 4'b1111, 2'b00, 4'b0001, 1, 1);
        applyStimulus(0, 1, 4'b1111, 2'b00, 4'b0001, 1, 0);

        // Let the monitor drain the queue within a bounded number of cycles
        for (int i = 0; i < 20 && expQ.size() > 0; i++) @(posedge iClk);
        #3;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
